// File: rtl/cclut_best_scan_ctrl_pkg.sv
// Shared widths, FSM encoding and the sort-key helper for the serial
// ccLUT best-pattern scan controller.
package cclut_best_scan_ctrl_pkg;

    localparam int MXPATB  = 4;   // pattern id width, lsb = bend direction
    localparam int MXKEYB  = 5;   // key half-strip width within one group
    localparam int MXKEYBX = 8;   // {group index, key}
    localparam int MXPATC  = 12;  // comparator code width
    localparam int NGRP    = 5;   // groups scanned per set (max 8)
    localparam int MXDROPB = 8;   // dropped-start counter width
    localparam int IDXB    = 3;   // group index width

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Sort key is the pattern id with the bend bit shifted out; returned
    // zero-extended so callers can compare full-width values.
    function automatic logic [MXPATB-1:0] sort_key(input logic [MXPATB-1:0] pat);
        return pat >> 1;
    endfunction

endpackage

// File: rtl/cclut_best_scan_ctrl_cand_cmp.sv
// Shared comparator: decides whether the candidate replaces the running best.
// The first group always loads; later groups win only on a strictly greater
// sort key, so ties stay with the lowest group index.
module cclut_best_scan_ctrl_cand_cmp
    import cclut_best_scan_ctrl_pkg::*;
(
    input  logic [MXPATB-1:0] cand_pat,
    input  logic [MXPATB-1:0] best_pat,
    input  logic              first,
    output logic              replace
);

    // Strict-greater compare on the bend-stripped pattern id.
    always_comb begin
        replace = first || (sort_key(cand_pat) > sort_key(best_pat));
    end

endmodule

// File: rtl/cclut_best_scan_ctrl.sv
// Serial 1-of-NGRP best-pattern selector. A start in IDLE latches one
// candidate per group; the groups are then walked one per clock through a
// single comparator, and the winner is published with a one-cycle strobe.
//
// Handshake: start is a single-cycle request that is only honoured in IDLE
// (and only without abort); there is no ready signal, so any start seen
// while busy is dropped and recorded in overflow/drop_cnt. best_vld is a
// one-cycle pulse; best_* hold their value until the next best_vld.
module cclut_best_scan_ctrl
    import cclut_best_scan_ctrl_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     clear_stat,
    input  logic [NGRP*MXPATB-1:0]   pat_in,
    input  logic [NGRP*MXKEYB-1:0]   key_in,
    input  logic [NGRP*MXPATC-1:0]   carry_in,
    output logic                     busy,
    output logic                     best_vld,
    output logic [MXPATB-1:0]        best_pat,
    output logic [MXKEYBX-1:0]       best_key,
    output logic [MXPATC-1:0]        best_carry,
    output logic                     overflow,
    output logic [MXDROPB-1:0]       drop_cnt,
    output logic                     scan_state
);

    state_t state;
    state_t state_nxt;

    logic [IDXB-1:0]    idx;
    logic [MXPATB-1:0]  pat_l   [NGRP];
    logic [MXKEYB-1:0]  key_l   [NGRP];
    logic [MXPATC-1:0]  carry_l [NGRP];

    logic [MXPATB-1:0]  run_pat;
    logic [MXKEYBX-1:0] run_key;
    logic [MXPATC-1:0]  run_carry;

    logic [MXPATB-1:0]  cand_pat;
    logic [MXKEYBX-1:0] cand_key;
    logic [MXPATC-1:0]  cand_carry;

    logic accept;
    logic scan_step;
    logic finish;
    logic first;
    logic last;
    logic replace;
    logic drop;

    assign busy       = (state == SCAN);
    assign scan_state = state;
    assign first      = (idx == '0);
    assign last       = (idx == IDXB'(NGRP - 1));
    assign drop       = (state == SCAN) && start;

    // Select the candidate for the group currently being scanned.
    always_comb begin
        cand_pat   = pat_l[idx];
        cand_key   = {idx, key_l[idx]};
        cand_carry = carry_l[idx];
    end

    cclut_best_scan_ctrl_cand_cmp u_cmp (
        .cand_pat (cand_pat),
        .best_pat (run_pat),
        .first    (first),
        .replace  (replace)
    );

    // Next-state and per-cycle control; abort always wins in both states.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        scan_step = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = SCAN;
                    accept    = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    scan_step = 1'b1;
                    if (last) begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Capture the candidate set on an accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < NGRP; g++) begin
                pat_l[g]   <= '0;
                key_l[g]   <= '0;
                carry_l[g] <= '0;
            end
        end else if (accept) begin
            for (int g = 0; g < NGRP; g++) begin
                pat_l[g]   <= pat_in[g*MXPATB +: MXPATB];
                key_l[g]   <= key_in[g*MXKEYB +: MXKEYB];
                carry_l[g] <= carry_in[g*MXPATC +: MXPATC];
            end
        end
    end

    // Group index: cleared on accept, finish or abort, otherwise advances.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                      idx <= '0;
        else if (accept || finish || abort) idx <= '0;
        else if (scan_step)                idx <= idx + 1'b1;
    end

    // Running best, private to the scan so best_* stay stable mid-scan.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_pat   <= '0;
            run_key   <= '0;
            run_carry <= '0;
        end else if (scan_step && replace) begin
            run_pat   <= cand_pat;
            run_key   <= cand_key;
            run_carry <= cand_carry;
        end
    end

    // Publish the winner on the final scan edge with a one-cycle strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            best_vld   <= 1'b0;
            best_pat   <= '0;
            best_key   <= '0;
            best_carry <= '0;
        end else begin
            best_vld <= finish;
            if (finish) begin
                best_pat   <= replace ? cand_pat   : run_pat;
                best_key   <= replace ? cand_key   : run_key;
                best_carry <= replace ? cand_carry : run_carry;
            end
        end
    end

    // Dropped-start statistics; clear_stat overrides a same-cycle drop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear_stat) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cclut_best_scan_ctrl.sv
// Directed and randomized bench for the serial best-pattern scan controller.
module tb_cclut_best_scan_ctrl;
    import cclut_best_scan_ctrl_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic                   clear_stat = 1'b0;
    logic [NGRP*MXPATB-1:0] pat_in = '0;
    logic [NGRP*MXKEYB-1:0] key_in = '0;
    logic [NGRP*MXPATC-1:0] carry_in = '0;
    logic                   busy;
    logic                   best_vld;
    logic [MXPATB-1:0]      best_pat;
    logic [MXKEYBX-1:0]     best_key;
    logic [MXPATC-1:0]      best_carry;
    logic                   overflow;
    logic [MXDROPB-1:0]     drop_cnt;
    logic                   scan_state;

    cclut_best_scan_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .clear_stat (clear_stat),
        .pat_in     (pat_in),
        .key_in     (key_in),
        .carry_in   (carry_in),
        .busy       (busy),
        .best_vld   (best_vld),
        .best_pat   (best_pat),
        .best_key   (best_key),
        .best_carry (best_carry),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .scan_state (scan_state)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    logic [MXPATB-1:0]  pa [NGRP];
    logic [MXKEYB-1:0]  ka [NGRP];
    logic [MXPATC-1:0]  ca [NGRP];

    logic [MXPATB-1:0]  exp_pat   = '0;
    logic [MXKEYBX-1:0] exp_key   = '0;
    logic [MXPATC-1:0]  exp_carry = '0;
    logic [MXPATB-1:0]  nxt_pat;
    logic [MXKEYBX-1:0] nxt_key;
    logic [MXPATC-1:0]  nxt_carry;
    int                 exp_drop = 0;
    logic               exp_ovf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_bus();
        for (int g = 0; g < NGRP; g++) begin
            pat_in[g*MXPATB +: MXPATB]   = pa[g];
            key_in[g*MXKEYB +: MXKEYB]   = ka[g];
            carry_in[g*MXPATC +: MXPATC] = ca[g];
        end
    endtask

    task automatic scramble_bus();
        pat_in   = (NGRP*MXPATB)'($urandom);
        key_in   = (NGRP*MXKEYB)'($urandom);
        carry_in = (NGRP*MXPATC)'($urandom);
    endtask

    task automatic rand_arrays(input int pmax);
        for (int g = 0; g < NGRP; g++) begin
            pa[g] = MXPATB'($urandom_range(pmax, 0));
            ka[g] = MXKEYB'($urandom_range(31, 0));
            ca[g] = MXPATC'($urandom_range(4095, 0));
        end
    endtask

    // Reference: first group whose pattern/2 is the maximum of the set.
    task automatic model();
        int best;
        int best_sk;
        logic [2:0] bi;
        best    = 0;
        best_sk = int'(pa[0]) / 2;
        for (int g = 1; g < NGRP; g++) begin
            if (int'(pa[g]) / 2 > best_sk) begin
                best    = g;
                best_sk = int'(pa[g]) / 2;
            end
        end
        bi        = 3'(best);
        nxt_pat   = pa[best];
        nxt_key   = {bi, ka[best]};
        nxt_carry = ca[best];
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
        check({tag, "_ovf"},  32'(overflow), 32'(exp_ovf));
    endtask

    // One full accepted scan: start at E0, result strobe after E5.
    task automatic run_set(input string tag);
        model();
        drive_bus();
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_e0"}, 32'(busy), 32'd1);
        check({tag, "_vld_e0"},  32'(best_vld), 32'd0);
        for (int k = 1; k <= NGRP; k++) begin
            scramble_bus();
            step();
            if (k < NGRP) begin
                check({tag, "_vld_mid"},  32'(best_vld), 32'd0);
                check({tag, "_busy_mid"}, 32'(busy), 32'd1);
                check({tag, "_hold_mid"}, 32'(best_pat), 32'(exp_pat));
            end else begin
                check({tag, "_vld"},   32'(best_vld), 32'd1);
                check({tag, "_busy"},  32'(busy), 32'd0);
                check({tag, "_pat"},   32'(best_pat), 32'(nxt_pat));
                check({tag, "_key"},   32'(best_key), 32'(nxt_key));
                check({tag, "_carry"}, 32'(best_carry), 32'(nxt_carry));
                exp_pat   = nxt_pat;
                exp_key   = nxt_key;
                exp_carry = nxt_carry;
            end
        end
        step();
        check({tag, "_vld_off"}, 32'(best_vld), 32'd0);
        check({tag, "_hold"},    32'(best_key), 32'(exp_key));
        check_stats(tag);
    endtask

    initial begin
        // Reset state.
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vld",  32'(best_vld), 32'd0);
        check("rst_pat",  32'(best_pat), 32'd0);
        check("rst_key",  32'(best_key), 32'd0);
        check("rst_carry", 32'(best_carry), 32'd0);
        check_stats("rst");
        reset_n = 1'b1;
        step();

        // Single ascending set: group 4 wins.
        pa = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
        ka = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        ca = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
        run_set("single");
        check("single_key85", 32'(best_key), 32'h85);

        // Tie on sort key with bend bit differing: group 0 keeps it.
        pa = '{4'd9, 4'd8, 4'd9, 4'd3, 4'd0};
        ka = '{5'd17, 5'd18, 5'd19, 5'd20, 5'd21};
        ca = '{12'hA01, 12'hA02, 12'hA03, 12'hA04, 12'hA05};
        run_set("tie");
        check("tie_pat9", 32'(best_pat), 32'd9);

        // All-zero patterns: group 0 with its own key and carry.
        pa = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        ka = '{5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
        ca = '{12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'hC04};
        run_set("zero");
        check("zero_key", 32'(best_key), 32'h07);

        // Random sets, half with a narrow pattern range to force ties.
        for (int i = 0; i < 20; i++) begin
            rand_arrays((i % 2 == 0) ? 15 : 3);
            run_set("rand");
        end

        // Abort plus start in IDLE: nothing starts, nothing counted.
        scramble_bus();
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check_stats("idle_abort");
        step();
        check("idle_abort_vld", 32'(best_vld), 32'd0);

        // Abort on E3 of a scan, then an immediate start on E4.
        rand_arrays(15);
        drive_bus();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_vld",  32'(best_vld), 32'd0);
        check("abort_pat",  32'(best_pat), 32'(exp_pat));
        check("abort_key",  32'(best_key), 32'(exp_key));
        check("abort_carry", 32'(best_carry), 32'(exp_carry));
        rand_arrays(15);
        run_set("after_abort");

        // Start held high: five drops per result, saturating at all-ones.
        for (int r = 0; r < 52; r++) begin
            rand_arrays(15);
            model();
            drive_bus();
            start = 1'b1;
            step();
            for (int k = 1; k <= NGRP; k++) begin
                scramble_bus();
                step();
            end
            exp_drop = (5 * (r + 1) > 255) ? 255 : 5 * (r + 1);
            exp_ovf  = 1'b1;
            check("b2b_vld",   32'(best_vld), 32'd1);
            check("b2b_pat",   32'(best_pat), 32'(nxt_pat));
            check("b2b_key",   32'(best_key), 32'(nxt_key));
            check("b2b_carry", 32'(best_carry), 32'(nxt_carry));
            check_stats("b2b");
            exp_pat   = nxt_pat;
            exp_key   = nxt_key;
            exp_carry = nxt_carry;
        end
        start      = 1'b0;
        clear_stat = 1'b1;
        step();
        clear_stat = 1'b0;
        exp_drop   = 0;
        exp_ovf    = 1'b0;
        check_stats("clear");

        // Clear and drop on the same edge: clear wins.
        rand_arrays(15);
        model();
        drive_bus();
        start = 1'b1;
        step();
        step();
        exp_drop = 1;
        exp_ovf  = 1'b1;
        check_stats("drop_one");
        clear_stat = 1'b1;
        step();
        clear_stat = 1'b0;
        start      = 1'b0;
        exp_drop   = 0;
        exp_ovf    = 1'b0;
        check_stats("clear_vs_drop");
        step();
        step();
        step();
        check("cvd_vld", 32'(best_vld), 32'd1);
        check("cvd_pat", 32'(best_pat), 32'(nxt_pat));
        check("cvd_key", 32'(best_key), 32'(nxt_key));
        exp_pat   = nxt_pat;
        exp_key   = nxt_key;
        exp_carry = nxt_carry;
        step();

        // Asynchronous reset in the middle of a scan, with a drop recorded.
        rand_arrays(15);
        drive_bus();
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_vld",   32'(best_vld), 32'd0);
        check("arst_pat",   32'(best_pat), 32'd0);
        check("arst_key",   32'(best_key), 32'd0);
        check("arst_carry", 32'(best_carry), 32'd0);
        check("arst_ovf",   32'(overflow), 32'd0);
        check("arst_drop",  32'(drop_cnt), 32'd0);
        step();
        reset_n   = 1'b1;
        exp_pat   = '0;
        exp_key   = '0;
        exp_carry = '0;
        exp_drop  = 0;
        exp_ovf   = 1'b0;
        step();
        rand_arrays(15);
        run_set("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
